// File: rtl/neighbor_exchange_receiver_pkg.sv
// Shared types and constants for the neighbor halo exchange receiver.
// Covers the eight-port topology, the default tile geometry and the FSM state encoding.
package neighbor_exchange_receiver_pkg;

    localparam int NEIGHBOR_COUNT    = 8;
    localparam int PTR_W             = $clog2(NEIGHBOR_COUNT);
    localparam int TILE_SIZE_DEFAULT = 128;
    localparam int CW                = $clog2(TILE_SIZE_DEFAULT);
    localparam int VALUE_W           = 8;

    typedef struct packed {
        logic [CW-1:0]      row;
        logic [CW-1:0]      column;
        logic [VALUE_W-1:0] value;
    } halo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXCHANGE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // First requester at or after ptr, wrapping; returns ptr when nothing requests.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NEIGHBOR_COUNT-1:0] req,
                                                 input logic [PTR_W-1:0]          ptr);
        logic [PTR_W-1:0] idx;
        rr_pick = ptr;
        for (int k = NEIGHBOR_COUNT - 1; k >= 0; k--) begin
            idx = ptr + PTR_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/neighbor_exchange_receiver_fifo.sv
// Per-neighbor FIFO with push, pop, count and full/empty flags.
// Reads come straight from storage, so the head entry is visible in the same cycle it is popped.
module neighbor_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/neighbor_exchange_receiver.sv
// Collects halo partial sums from eight neighbors into per-port FIFOs and merges them
// round-robin into a single accumulator write port with ready/valid hold semantics.
//   state    | meaning
//   IDLE     | waiting for start; all ports closed
//   EXCHANGE | ports open until every neighbor has flagged done
//   DRAIN    | ports closed, emptying FIFOs and output register
//   DONE     | one-cycle completion pulse, then back to IDLE
module neighbor_exchange_receiver
    import neighbor_exchange_receiver_pkg::*;
#(
    parameter int TILE_SIZE  = TILE_SIZE_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [VALUE_W-1:0]            neighbor_input_value        [NEIGHBOR_COUNT],
    input  logic [$clog2(TILE_SIZE)-1:0]  neighbor_input_row          [NEIGHBOR_COUNT],
    input  logic [$clog2(TILE_SIZE)-1:0]  neighbor_input_column       [NEIGHBOR_COUNT],
    input  logic [NEIGHBOR_COUNT-1:0]     neighbor_input_write_enable,
    input  logic [NEIGHBOR_COUNT-1:0]     neighbor_exchange_done,
    output logic [NEIGHBOR_COUNT-1:0]     neighbor_cts,
    output logic [$clog2(TILE_SIZE)-1:0]  accum_row,
    output logic [$clog2(TILE_SIZE)-1:0]  accum_column,
    output logic [VALUE_W-1:0]            accum_value,
    output logic                          accum_write_enable,
    input  logic                          accum_ready,
    output logic                          exchange_complete,
    output logic                          overflow_error
);

    localparam int COORD_W = $clog2(TILE_SIZE);
    localparam int ENTRY_W = 2 * COORD_W + VALUE_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    state_t                    state_q, state_d;
    logic [NEIGHBOR_COUNT-1:0] done_latched_q, done_latched_d;
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                      out_valid_q, out_valid_d;
    logic [COORD_W-1:0]        out_row_q, out_row_d;
    logic [COORD_W-1:0]        out_column_q, out_column_d;
    logic [VALUE_W-1:0]        out_value_q, out_value_d;
    logic                      overflow_q, overflow_d;

    logic [NEIGHBOR_COUNT-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty, port_open;
    logic [ENTRY_W-1:0]        fifo_pop_data [NEIGHBOR_COUNT];
    logic [CNT_W-1:0]          fifo_count    [NEIGHBOR_COUNT];

    logic                      out_free, grant_vld;
    logic [PTR_W-1:0]          grant_idx;

    for (genvar i = 0; i < NEIGHBOR_COUNT; i++) begin : g_port
        assign port_open[i] = (state_q == ST_EXCHANGE) && !done_latched_q[i]
                              && (fifo_count[i] < CNT_W'(FIFO_DEPTH));
        assign fifo_push[i] = neighbor_input_write_enable[i] && port_open[i] && !fifo_full[i];

        neighbor_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .reset_n     (reset_n),
            .push_i      (fifo_push[i]),
            .push_data_i ({neighbor_input_row[i], neighbor_input_column[i], neighbor_input_value[i]}),
            .pop_i       (fifo_pop[i]),
            .pop_data_o  (fifo_pop_data[i]),
            .count_o     (fifo_count[i]),
            .full_o      (fifo_full[i]),
            .empty_o     (fifo_empty[i])
        );
    end

    // The output slot frees up either because it is empty or because its entry leaves this cycle.
    assign out_free  = !out_valid_q || accum_ready;
    assign grant_idx = rr_pick(~fifo_empty, rr_ptr_q);
    assign grant_vld = (|(~fifo_empty)) && out_free;
    assign fifo_pop  = grant_vld ? (NEIGHBOR_COUNT'(1) << grant_idx) : '0;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_row_d    = out_row_q;
        out_column_d = out_column_q;
        out_value_d  = out_value_q;
        rr_ptr_d     = rr_ptr_q;
        if (grant_vld) begin
            out_valid_d = 1'b1;
            {out_row_d, out_column_d, out_value_d} = fifo_pop_data[grant_idx];
            rr_ptr_d    = grant_idx + PTR_W'(1);
        end else if (accum_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        done_latched_d = done_latched_q;
        overflow_d     = overflow_q | (|(neighbor_input_write_enable & ~port_open));
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_EXCHANGE;
                    done_latched_d = '0;
                end
            end
            ST_EXCHANGE: begin
                done_latched_d = done_latched_q | neighbor_exchange_done;
                if (&done_latched_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((&fifo_empty) && !out_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            done_latched_q <= '0;
            rr_ptr_q       <= '0;
            out_valid_q    <= 1'b0;
            out_row_q      <= '0;
            out_column_q   <= '0;
            out_value_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            done_latched_q <= done_latched_d;
            rr_ptr_q       <= rr_ptr_d;
            out_valid_q    <= out_valid_d;
            out_row_q      <= out_row_d;
            out_column_q   <= out_column_d;
            out_value_q    <= out_value_d;
            overflow_q     <= overflow_d;
        end
    end

    assign neighbor_cts       = port_open;
    assign accum_row          = out_row_q;
    assign accum_column       = out_column_q;
    assign accum_value        = out_value_q;
    assign accum_write_enable = out_valid_q;
    assign exchange_complete  = (state_q == ST_DONE);
    assign overflow_error     = overflow_q;

endmodule

// File: tb/tb_neighbor_exchange_receiver.sv
// Scoreboard bench for neighbor_exchange_receiver: directed writes push expected entries,
// a negedge monitor pops and compares on every accepted accumulator write.
module tb_neighbor_exchange_receiver;

    typedef struct packed {
        logic [6:0] row;
        logic [6:0] col;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       accum_ready = 1'b0;
    logic [7:0] nv [8];
    logic [6:0] nr [8];
    logic [6:0] nc [8];
    logic [7:0] nwe = '0;
    logic [7:0] ndone = '0;
    logic [7:0] cts;
    logic [6:0] accum_row, accum_column;
    logic [7:0] accum_value;
    logic       accum_write_enable, exchange_complete, overflow_error;

    exp_t sb [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   we_cycles = 0;
    int   pulses;
    int   base;

    neighbor_exchange_receiver #(.TILE_SIZE(128), .FIFO_DEPTH(4)) dut (
        .clk                         (clk),
        .reset_n                     (reset_n),
        .start                       (start),
        .neighbor_input_value        (nv),
        .neighbor_input_row          (nr),
        .neighbor_input_column       (nc),
        .neighbor_input_write_enable (nwe),
        .neighbor_exchange_done      (ndone),
        .neighbor_cts                (cts),
        .accum_row                   (accum_row),
        .accum_column                (accum_column),
        .accum_value                 (accum_value),
        .accum_write_enable          (accum_write_enable),
        .accum_ready                 (accum_ready),
        .exchange_complete           (exchange_complete),
        .overflow_error              (overflow_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && accum_write_enable) begin
            we_cycles++;
            if (accum_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h/%0h/%0h expected none",
                             accum_row, accum_column, accum_value);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_row", accum_row, mon_e.row);
                    check("sb_col", accum_column, mon_e.col);
                    check("sb_val", accum_value, mon_e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 8; i++) begin
            nv[i] = '0;
            nr[i] = '0;
            nc[i] = '0;
        end
        nwe = '0;
    endtask

    task automatic drive_write(input int port, input logic [6:0] row, input logic [6:0] col,
                               input logic [7:0] val, input bit expect_out);
        nr[port]  = row;
        nc[port]  = col;
        nv[port]  = val;
        nwe[port] = 1'b1;
        if (expect_out) sb.push_back('{row: row, col: col, val: val});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check(name, sb.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        accum_ready = 1'b1;
        repeat (3) tick();
        check("rst_we", accum_write_enable, 0);
        check("rst_row", accum_row, 0);
        check("rst_col", accum_column, 0);
        check("rst_val", accum_value, 0);
        check("rst_cts", cts, 0);
        check("rst_complete", exchange_complete, 0);
        check("rst_overflow", overflow_error, 0);
        reset_n = 1'b1;
        tick();

        // single write, latency and one-cycle enable
        start = 1'b1;
        tick();
        start = 1'b0;
        check("cts_exchange", cts, 8'hFF);
        drive_write(3, 7'd5, 7'd9, 8'h2A, 1);
        tick();
        clear_inputs();
        check("lat_t1_we", accum_write_enable, 0);
        tick();
        check("lat_t2_we", accum_write_enable, 1);
        check("lat_t2_row", accum_row, 5);
        check("lat_t2_col", accum_column, 9);
        check("lat_t2_val", accum_value, 8'h2A);
        tick();
        check("lat_t3_we", accum_write_enable, 0);
        wait_drain("drain_single");

        // same-cycle writes on 0,1,2 then pointer continues from 3
        drive_write(0, 7'd1, 7'd1, 8'h10, 1);
        drive_write(1, 7'd2, 7'd2, 8'h11, 1);
        drive_write(2, 7'd3, 7'd3, 8'h12, 1);
        tick();
        clear_inputs();
        wait_drain("drain_rr012");
        drive_write(3, 7'd4, 7'd4, 8'h13, 1);
        drive_write(2, 7'd6, 7'd6, 8'h14, 1);
        tick();
        clear_inputs();
        wait_drain("drain_rr_ptr3");

        // backpressure fills port 5, next write overflows
        accum_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_write(5, 7'(k), 7'(k + 1), 8'hA0 + 8'(k), 1);
            tick();
        end
        clear_inputs();
        check("cts5_full", cts[5], 0);
        check("cts4_open", cts[4], 1);
        check("ovf_before", overflow_error, 0);
        check("hold_we", accum_write_enable, 1);
        check("hold_val", accum_value, 8'hA0);
        drive_write(5, 7'd99, 7'd99, 8'hEE, 0);
        tick();
        clear_inputs();
        check("ovf_set", overflow_error, 1);
        tick();
        check("hold_val_later", accum_value, 8'hA0);
        accum_ready = 1'b1;
        wait_drain("drain_port5");
        check("ovf_sticky", overflow_error, 1);

        // done with entries queued, drain then single completion pulse
        accum_ready = 1'b0;
        drive_write(0, 7'd10, 7'd20, 8'h55, 1);
        drive_write(1, 7'd11, 7'd21, 8'h66, 1);
        ndone = 8'h01;
        tick();
        clear_inputs();
        ndone = 8'hFE;
        tick();
        ndone = 8'h00;
        tick();
        tick();
        check("cts_drain", cts, 0);
        check("complete_in_drain", exchange_complete, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored", cts, 0);
        accum_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (exchange_complete) begin
                pulses++;
                check("sb_at_complete", sb.size(), 0);
            end
        end
        check("complete_pulses", pulses, 1);
        check("cts_idle", cts, 0);

        // reset in DRAIN with entries queued
        start = 1'b1;
        tick();
        start = 1'b0;
        accum_ready = 1'b0;
        drive_write(2, 7'd30, 7'd31, 8'h77, 0);
        drive_write(4, 7'd32, 7'd33, 8'h78, 0);
        drive_write(6, 7'd34, 7'd35, 8'h79, 0);
        ndone = 8'hFF;
        tick();
        clear_inputs();
        ndone = 8'h00;
        tick();
        tick();
        check("cts_drain2", cts, 0);
        check("we_before_reset", accum_write_enable, 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", accum_write_enable, 0);
        check("mid_rst_row", accum_row, 0);
        check("mid_rst_col", accum_column, 0);
        check("mid_rst_val", accum_value, 0);
        check("mid_rst_cts", cts, 0);
        check("mid_rst_ovf", overflow_error, 0);
        base = we_cycles;
        tick();
        tick();
        reset_n = 1'b1;
        accum_ready = 1'b1;
        repeat (10) tick();
        check("no_write_after_reset", we_cycles - base, 0);

        // fresh phase still works after reset
        start = 1'b1;
        tick();
        start = 1'b0;
        drive_write(7, 7'd100, 7'd50, 8'h7E, 1);
        tick();
        clear_inputs();
        wait_drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
